wb_stage_p: RTL and testbench

Parametrised writeback pipeline stage for the 5-stage CPU. It registers the MEM-stage result bundle and selects the register-file write data from ALU, memory, link/PC-return or immediate. It extracts byte loads with optional sign extension and honours stall and flush with a valid bit. Each instruction commits exactly once, so RF writes and returns are never repeated while the pipeline is stalled. It sits between the MEM stage and the register file / PC-return logic, and also drives a last-write forwarding port.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/load_extract.sv | 32 +++
 rtl/wb_stage_p.sv | 150 +++++++++++++++
 tb/tb_wb_stage_p.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback result-select encoding and default datapath sizes.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    typedef enum logic [1:0] {
        SEL_ALU   = 2'd0,
        SEL_MEM   = 2'd1,
        SEL_PCRET = 2'd2,
        SEL_IMM   = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/load_extract.sv
// Byte-lane extraction for loads: picks one byte of the memory word and zero- or
// sign-extends it to the datapath width; full-word loads pass straight through.
module load_extract
    import cpu_pkg::*;
#(
    parameter int  DATA_W = cpu_pkg::DATA_W,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] word,
    input  logic              ld_byte,
    input  logic              ld_signed,
    input  logic [OFF_W-1:0]  byte_off,
    output logic [DATA_W-1:0] result
);

    function automatic logic [DATA_W-1:0] extend_byte(input logic signed [7:0] b,
                                                      input logic           is_signed);
        if (is_signed)
            return {{(DATA_W-8){b[7]}}, b};
        return {{(DATA_W-8){1'b0}}, b};
    endfunction

    logic [DATA_W-1:0] shifted;
    logic signed [7:0] lane;

    always_comb begin
        shifted = word >> {byte_off, 3'b000};
        lane    = shifted[7:0];
        result  = ld_byte ? extend_byte(lane, ld_signed) : word;
    end

endmodule

// File: rtl/wb_stage_p.sv
// Writeback stage: registers the MEM bundle, commits each instruction exactly once
// across stalls, and keeps a last-write forwarding copy. Optional retire counter
// is enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_p
    import cpu_pkg::*;
#(
    parameter int  DATA_W  = cpu_pkg::DATA_W,
    parameter int  REG_AW  = cpu_pkg::REG_AW,
    parameter int  R0_ZERO = 1,
    parameter int  CNT_W   = 32,
    localparam int OFF_W   = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        in_sel,
    input  logic              in_regwrite,
    input  logic              in_ret,
    input  logic [REG_AW-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_pcret,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_ld_byte,
    input  logic              in_ld_signed,
    input  logic [OFF_W-1:0]  in_byte_off,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              ret,
    output logic [DATA_W-1:0] pc_ret,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              valid_p0;
    logic              done_p0;
    wb_sel_e           sel_p0;
    logic              regwrite_p0;
    logic              ret_p0;
    logic [REG_AW-1:0] waddr_p0;
    logic [DATA_W-1:0] alu_p0;
    logic [DATA_W-1:0] mem_p0;
    logic [DATA_W-1:0] pcret_p0;
    logic [DATA_W-1:0] imm_p0;
    logic              ld_byte_p0;
    logic              ld_signed_p0;
    logic [OFF_W-1:0]  byte_off_p0;

    logic              commit;
    logic [DATA_W-1:0] mem_result;

    // ---- stage p0: MEM -> WB register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_p0     <= 1'b0;
            done_p0      <= 1'b0;
            sel_p0       <= SEL_ALU;
            regwrite_p0  <= 1'b0;
            ret_p0       <= 1'b0;
            waddr_p0     <= '0;
            alu_p0       <= '0;
            mem_p0       <= '0;
            pcret_p0     <= '0;
            imm_p0       <= '0;
            ld_byte_p0   <= 1'b0;
            ld_signed_p0 <= 1'b0;
            byte_off_p0  <= '0;
        end else if (flush) begin
            valid_p0 <= 1'b0;
            done_p0  <= 1'b0;
        end else if (stall) begin
            // A held valid instruction has committed once; block repeats.
            done_p0 <= valid_p0;
        end else begin
            valid_p0     <= in_valid;
            done_p0      <= 1'b0;
            sel_p0       <= wb_sel_e'(in_sel);
            regwrite_p0  <= in_regwrite;
            ret_p0       <= in_ret;
            waddr_p0     <= in_waddr;
            alu_p0       <= in_alu;
            mem_p0       <= in_mem;
            pcret_p0     <= in_pcret;
            imm_p0       <= in_imm;
            ld_byte_p0   <= in_ld_byte;
            ld_signed_p0 <= in_ld_signed;
            byte_off_p0  <= in_byte_off;
        end
    end

    load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .word      (mem_p0),
        .ld_byte   (ld_byte_p0),
        .ld_signed (ld_signed_p0),
        .byte_off  (byte_off_p0),
        .result    (mem_result)
    );

    always_comb begin
        commit   = valid_p0 & ~done_p0;
        rf_we    = commit & regwrite_p0 & ~((R0_ZERO != 0) && (waddr_p0 == '0));
        ret      = commit & ret_p0;
        rf_waddr = waddr_p0;
        pc_ret   = pcret_p0;
        rf_wdata = alu_p0;
        case (sel_p0)
            SEL_ALU:   rf_wdata = alu_p0;
            SEL_MEM:   rf_wdata = mem_result;
            SEL_PCRET: rf_wdata = pcret_p0;
            SEL_IMM:   rf_wdata = imm_p0;
            default:   rf_wdata = alu_p0;
        endcase
    end

    // ---- forwarding copy of the last committed write (survives flush) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if (rf_we) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= rf_waddr;
            fwd_data  <= rf_wdata;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retire_q <= '0;
        else if (commit)
            retire_q <= retire_q + CNT_W'(1);
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage_p.sv
// Self-checking bench for wb_stage_p: directed scenarios plus randomized traffic
// checked against a bundle-level reference model.
module tb_wb_stage_p;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [1:0]        in_sel;
    logic              in_regwrite;
    logic              in_ret;
    logic [REG_AW-1:0] in_waddr;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_mem;
    logic [DATA_W-1:0] in_pcret;
    logic [DATA_W-1:0] in_imm;
    logic              in_ld_byte;
    logic              in_ld_signed;
    logic              in_byte_off;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              ret;
    logic [DATA_W-1:0] pc_ret;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  retire_cnt;

    wb_stage_p #(
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW),
        .R0_ZERO (1),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_sel       (in_sel),
        .in_regwrite  (in_regwrite),
        .in_ret       (in_ret),
        .in_waddr     (in_waddr),
        .in_alu       (in_alu),
        .in_mem       (in_mem),
        .in_pcret     (in_pcret),
        .in_imm       (in_imm),
        .in_ld_byte   (in_ld_byte),
        .in_ld_signed (in_ld_signed),
        .in_byte_off  (in_byte_off),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .ret          (ret),
        .pc_ret       (pc_ret),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sel;
        bit regwrite;
        bit is_ret;
        int waddr;
        int alu;
        int mem;
        int pcret;
        int imm;
        bit ld_byte;
        bit ld_signed;
        int off;
    } bundle_t;

    // Reference model: the instruction occupying the stage and whether it has retired.
    bundle_t m_b;
    bit      m_valid;
    bit      m_retired;
    bit      m_fwd_v;
    int      m_fwd_a;
    int      m_fwd_d;
    int      m_cnt;

    int n_vec;
    int n_err;

    function automatic int load_value(bundle_t b);
        int byte_v;
        if (!b.ld_byte)
            return b.mem;
        byte_v = (b.mem / (1 << (8 * b.off))) % 256;
        if (b.ld_signed && byte_v >= 128)
            return (byte_v - 256 + 65536) % 65536;
        return byte_v;
    endfunction

    function automatic int wb_value(bundle_t b);
        case (b.sel)
            0:       return b.alu;
            1:       return load_value(b);
            2:       return b.pcret;
            default: return b.imm;
        endcase
    endfunction

    function automatic int exp_cnt();
`ifdef WB_RETIRE_CNT_EN
        return m_cnt % (1 << CNT_W);
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit retiring;
        retiring = m_valid && !m_retired;
        chk("rf_we", 32'(rf_we), 32'(retiring && m_b.regwrite && m_b.waddr != 0));
        chk("ret", 32'(ret), 32'(retiring && m_b.is_ret));
        chk("rf_waddr", 32'(rf_waddr), 32'(m_b.waddr));
        chk("rf_wdata", 32'(rf_wdata), 32'(wb_value(m_b)));
        chk("pc_ret", 32'(pc_ret), 32'(m_b.pcret));
        chk("fwd_valid", 32'(fwd_valid), 32'(m_fwd_v));
        chk("fwd_addr", 32'(fwd_addr), 32'(m_fwd_a));
        chk("fwd_data", 32'(fwd_data), 32'(m_fwd_d));
        chk("retire_cnt", 32'(retire_cnt), 32'(exp_cnt()));
    endtask

    task automatic model_clear();
        m_b = '{default: 0};
        m_valid = 0;
        m_retired = 0;
        m_fwd_v = 0;
        m_fwd_a = 0;
        m_fwd_d = 0;
        m_cnt = 0;
    endtask

    // Advance one clock: model reacts to the driven inputs, then outputs are checked.
    task automatic tick();
        bit retiring;
        retiring = m_valid && !m_retired;
        if (retiring && m_b.regwrite && m_b.waddr != 0) begin
            m_fwd_v = 1;
            m_fwd_a = m_b.waddr;
            m_fwd_d = wb_value(m_b);
        end
        if (retiring)
            m_cnt++;
        if (flush) begin
            m_valid = 0;
            m_retired = 0;
        end else if (stall) begin
            m_retired = m_retired || retiring;
        end else begin
            m_b.sel       = int'(in_sel);
            m_b.regwrite  = in_regwrite;
            m_b.is_ret    = in_ret;
            m_b.waddr     = int'(in_waddr);
            m_b.alu       = int'(in_alu);
            m_b.mem       = int'(in_mem);
            m_b.pcret     = int'(in_pcret);
            m_b.imm       = int'(in_imm);
            m_b.ld_byte   = in_ld_byte;
            m_b.ld_signed = in_ld_signed;
            m_b.off       = int'(in_byte_off);
            m_valid       = in_valid;
            m_retired     = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic rand_in();
        in_valid     = ($urandom_range(0, 3) != 0);
        in_sel       = 2'($urandom);
        in_regwrite  = ($urandom_range(0, 3) != 0);
        in_ret       = ($urandom_range(0, 4) == 0);
        in_waddr     = 4'($urandom);
        in_alu       = 16'($urandom);
        in_mem       = 16'($urandom);
        in_pcret     = 16'($urandom);
        in_imm       = 16'($urandom);
        in_ld_byte   = 1'($urandom);
        in_ld_signed = 1'($urandom);
        in_byte_off  = 1'($urandom);
    endtask

    task automatic valid_write(input logic [1:0] sel, input logic [3:0] waddr);
        rand_in();
        stall = 0;
        flush = 0;
        in_valid = 1;
        in_regwrite = 1;
        in_ret = 0;
        in_sel = sel;
        in_waddr = waddr;
    endtask

    // Asynchronous reset between clock edges, released at the next falling edge.
    task automatic do_reset();
        #2;
        rst = 0;
        #1;
        model_clear();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_ret", 32'(ret), 32'd0);
        chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_pc_ret", 32'(pc_ret), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_clear();
        rst = 0;
        stall = 0;
        flush = 0;
        rand_in();
        in_valid = 0;
        #3;
        check_all();
        @(negedge clk);
        rst = 1;

        // Warm-up traffic so the mid-traffic reset has something to clear.
        for (int i = 0; i < 20; i++) begin
            rand_in();
            stall = ($urandom_range(0, 3) == 0);
            flush = 0;
            tick();
        end
        do_reset();

        valid_write(2'd0, 4'd3);
        in_alu = 16'h1234;
        tick();
        chk("first_after_rst_we", 32'(rf_we), 32'd1);
        chk("first_after_rst_data", 32'(rf_wdata), 32'h1234);

        valid_write(2'd1, 4'd4);
        in_mem = 16'h80F1; in_ld_byte = 1; in_byte_off = 1; in_ld_signed = 1;
        tick();
        chk("ldb_off1_signed", 32'(rf_wdata), 32'hFF80);
        valid_write(2'd1, 4'd4);
        in_mem = 16'h80F1; in_ld_byte = 1; in_byte_off = 1; in_ld_signed = 0;
        tick();
        chk("ldb_off1_unsigned", 32'(rf_wdata), 32'h0080);
        valid_write(2'd1, 4'd4);
        in_mem = 16'h80F1; in_ld_byte = 1; in_byte_off = 0; in_ld_signed = 1;
        tick();
        chk("ldb_off0_signed", 32'(rf_wdata), 32'hFFF1);

        valid_write(2'd2, 4'd7);
        in_pcret = 16'h0042;
        in_ret = 1;
        tick();
        chk("stall_ret_first", 32'(ret), 32'd1);
        chk("stall_we_first", 32'(rf_we), 32'd1);
        for (int i = 0; i < 3; i++) begin
            rand_in();
            stall = 1;
            tick();
            chk("stall_ret_held", 32'(ret), 32'd0);
            chk("stall_we_held", 32'(rf_we), 32'd0);
            chk("stall_pc_ret", 32'(pc_ret), 32'h0042);
        end

        // Reset while a valid instruction is held by stall.
        valid_write(2'd0, 4'd6);
        tick();
        rand_in();
        stall = 1;
        tick();
        do_reset();
        valid_write(2'd3, 4'd2);
        in_imm = 16'h0BAD;
        tick();
        chk("after_stall_rst_we", 32'(rf_we), 32'd1);
        chk("after_stall_rst_data", 32'(rf_wdata), 32'h0BAD);

        valid_write(2'd0, 4'd9);
        in_alu = 16'hBEEF;
        tick();
        rand_in();
        in_valid = 1;
        in_regwrite = 1;
        in_ret = 1;
        stall = 1;
        flush = 1;
        tick();
        chk("flush_we", 32'(rf_we), 32'd0);
        chk("flush_ret", 32'(ret), 32'd0);
        chk("flush_fwd_addr", 32'(fwd_addr), 32'd9);
        chk("flush_fwd_data", 32'(fwd_data), 32'hBEEF);

        valid_write(2'd3, 4'd0);
        in_imm = 16'h5555;
        tick();
        chk("r0_we", 32'(rf_we), 32'd0);
        valid_write(2'd3, 4'd5);
        in_imm = 16'h0123;
        tick();
        chk("r0_fwd_unchanged", 32'(fwd_addr), 32'd9);
        chk("r5_we", 32'(rf_we), 32'd1);
        rand_in();
        in_valid = 0;
        tick();
        chk("r5_fwd_addr", 32'(fwd_addr), 32'd5);
        chk("r5_fwd_data", 32'(fwd_data), 32'h0123);

        // Retire counter: 17 retires wrap a 4-bit counter to 1.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            valid_write(2'($urandom), 4'($urandom));
            tick();
        end
        rand_in();
        in_valid = 0;
        tick();
`ifdef WB_RETIRE_CNT_EN
        chk("retire_wrap", 32'(retire_cnt), 32'd1);
`else
        chk("retire_tied", 32'(retire_cnt), 32'd0);
`endif

        // Ten back-to-back bundles followed by two stalled cycles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            valid_write(2'($urandom), 4'($urandom));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            rand_in();
            stall = 1;
            tick();
        end
        rand_in();
        in_valid = 0;
        stall = 0;
        tick();
`ifdef WB_RETIRE_CNT_EN
        chk("retire_ten", 32'(retire_cnt), 32'd10);
`else
        chk("retire_ten_tied", 32'(retire_cnt), 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            rand_in();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
